// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared encodings for the memory/writeback stage
package mem_wb_stage_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2,
        MEM_RSVD  = 2'd3
    } mem_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_wb_stage_timeout_ctr.sv
// mem_timeout_ctr: counts cycles spent waiting on a memory ack and flags expiry
module mem_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // Cleared whenever a new instruction is accepted, counts while waiting
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expire = (r_cnt == CW'(TIMEOUT));

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: registers EXE results, runs an optional load/store, issues one writeback
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RA_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [1:0]        i_mem_op,
    input  logic              i_wb_en,
    input  logic [RA_W-1:0]   i_rd_addr,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [DATA_W-1:0] o_dmem_addr,
    output logic [DATA_W-1:0] o_dmem_wdata,
    input  logic              i_dmem_ack,
    input  logic [DATA_W-1:0] i_dmem_rdata,
    output logic              o_wb_valid,
    output logic [RA_W-1:0]   o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_err_misalign,
    output logic              o_err_timeout
);

    state_e            r_state;
    state_e            w_next;
    logic              r_we;
    logic              r_wb_en;
    logic [RA_W-1:0]   r_rd;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [RA_W-1:0]   r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_err_mis;
    logic              r_err_to;
    logic              w_accept;
    logic              w_is_mem;
    logic              w_misalign;
    logic              w_in_mem;
    logic              w_load_done;
    logic              w_expire;

    assign w_in_mem    = (r_state == S_MEM);
    assign o_in_ready  = !w_in_mem;
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_is_mem    = (i_mem_op == MEM_LOAD) || (i_mem_op == MEM_STORE);
    assign w_misalign  = w_is_mem && (i_alu_result[1:0] != 2'b00);
    assign w_load_done = w_in_mem && i_dmem_ack && !r_we && r_wb_en;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_accept),
        .i_inc    (w_in_mem),
        .o_expire (w_expire)
    );

    // Next state: an ack on the final counted cycle still wins over the timeout
    always_comb begin
        w_next = S_IDLE;
        if (w_in_mem)
            w_next = i_dmem_ack ? (w_load_done ? S_WB : S_IDLE) : (w_expire ? S_IDLE : S_MEM);
        else if (w_accept)
            w_next = (w_is_mem && !w_misalign) ? S_MEM : (!w_is_mem && i_wb_en) ? S_WB : S_IDLE;
    end

    // State, captured instruction fields, writeback registers and error flags
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_wb_en   <= 1'b0;
            r_rd      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_err_mis <= 1'b0;
            r_err_to  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_err_mis <= w_accept && w_misalign;
            if (w_in_mem && !i_dmem_ack && w_expire)
                r_err_to <= 1'b1;
            if (w_accept) begin
                r_we    <= (i_mem_op == MEM_STORE);
                r_wb_en <= i_wb_en;
                r_rd    <= i_rd_addr;
                r_addr  <= i_alu_result;
                r_wdata <= i_store_data;
            end
            if (w_accept && !w_is_mem && i_wb_en) begin
                r_wb_addr <= i_rd_addr;
                r_wb_data <= i_alu_result;
            end
            if (w_load_done) begin
                r_wb_addr <= r_rd;
                r_wb_data <= i_dmem_rdata;
            end
        end
    end

    assign o_dmem_req     = w_in_mem;
    assign o_dmem_we      = r_we;
    assign o_dmem_addr    = r_addr;
    assign o_dmem_wdata   = r_wdata;
    assign o_wb_valid     = (r_state == S_WB);
    assign o_wb_addr      = r_wb_addr;
    assign o_wb_data      = r_wb_data;
    assign o_err_misalign = r_err_mis;
    assign o_err_timeout  = r_err_to;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed checks of ALU, load, store, misalign, timeout and reset behaviour
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [1:0]  mem_op;
    logic        wb_en;
    logic [3:0]  rd_addr;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err_misalign;
    logic        err_timeout;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(32), .RA_W(4), .TIMEOUT(15)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_alu_result   (alu_result),
        .i_store_data   (store_data),
        .i_mem_op       (mem_op),
        .i_wb_en        (wb_en),
        .i_rd_addr      (rd_addr),
        .o_dmem_req     (dmem_req),
        .o_dmem_we      (dmem_we),
        .o_dmem_addr    (dmem_addr),
        .o_dmem_wdata   (dmem_wdata),
        .i_dmem_ack     (dmem_ack),
        .i_dmem_rdata   (dmem_rdata),
        .o_wb_valid     (wb_valid),
        .o_wb_addr      (wb_addr),
        .o_wb_data      (wb_data),
        .o_err_misalign (err_misalign),
        .o_err_timeout  (err_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic we, input logic [3:0] rd);
        in_valid   = 1'b1;
        mem_op     = op;
        alu_result = alu;
        store_data = sd;
        wb_en      = we;
        rd_addr    = rd;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0;
        mem_op = 2'd0; wb_en = 1'b0; rd_addr = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        tick(); tick();
        chk("rst_req", dmem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_err_to", err_timeout, 0);
        chk("rst_err_mis", err_misalign, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", in_ready, 1);

        // single ALU op
        issue(2'd0, 32'h2A, 32'h0, 1'b1, 4'd3);
        tick();
        in_valid = 1'b0;
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_data", wb_data, 32'h2A);
        chk("alu_wb_addr", wb_addr, 3);
        tick();
        chk("alu_wb_drop", wb_valid, 0);
        chk("alu_wb_hold", wb_data, 32'h2A);

        // three back-to-back ALU ops
        issue(2'd0, 32'h100, 32'h0, 1'b1, 4'd5);
        tick();
        chk("b2b0_valid", wb_valid, 1);
        chk("b2b0_data", wb_data, 32'h100);
        chk("b2b0_ready", in_ready, 1);
        issue(2'd0, 32'h101, 32'h0, 1'b1, 4'd6);
        tick();
        chk("b2b1_valid", wb_valid, 1);
        chk("b2b1_data", wb_data, 32'h101);
        chk("b2b1_ready", in_ready, 1);
        issue(2'd0, 32'h102, 32'h0, 1'b1, 4'd7);
        tick();
        in_valid = 1'b0;
        chk("b2b2_valid", wb_valid, 1);
        chk("b2b2_data", wb_data, 32'h102);
        chk("b2b2_addr", wb_addr, 7);
        tick();
        chk("b2b_end", wb_valid, 0);

        // load, ack on the third request cycle
        issue(2'd1, 32'h100, 32'h0, 1'b1, 4'd7);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("ld_req", dmem_req, 1);
            chk("ld_we", dmem_we, 0);
            chk("ld_addr", dmem_addr, 32'h100);
            chk("ld_ready", in_ready, 0);
            chk("ld_no_wb", wb_valid, 0);
            if (k == 2) begin
                dmem_ack = 1'b1;
                dmem_rdata = 32'hDEADBEEF;
            end
            tick();
        end
        dmem_ack = 1'b0;
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);
        chk("ld_wb_addr", wb_addr, 7);
        chk("ld_req_drop", dmem_req, 0);
        chk("ld_ready_back", in_ready, 1);
        tick();
        chk("ld_wb_end", wb_valid, 0);

        // store, no writeback even with wb_en set
        issue(2'd2, 32'h104, 32'h55, 1'b1, 4'd9);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("st_req", dmem_req, 1);
            chk("st_we", dmem_we, 1);
            chk("st_addr", dmem_addr, 32'h104);
            chk("st_wdata", dmem_wdata, 32'h55);
            if (k == 1) dmem_ack = 1'b1;
            tick();
        end
        dmem_ack = 1'b0;
        chk("st_req_drop", dmem_req, 0);
        chk("st_no_wb", wb_valid, 0);
        chk("st_ready", in_ready, 1);
        tick();
        chk("st_no_wb2", wb_valid, 0);
        chk("st_wb_hold", wb_data, 32'hDEADBEEF);

        // misaligned load
        issue(2'd1, 32'h102, 32'h0, 1'b1, 4'd1);
        tick();
        in_valid = 1'b0;
        chk("mis_pulse", err_misalign, 1);
        chk("mis_no_req", dmem_req, 0);
        chk("mis_no_wb", wb_valid, 0);
        tick();
        chk("mis_pulse_end", err_misalign, 0);
        chk("mis_no_req2", dmem_req, 0);
        chk("mis_no_wb2", wb_valid, 0);

        // reserved op behaves as NONE; NONE without wb_en retires silently
        issue(2'd3, 32'h77, 32'h0, 1'b1, 4'd2);
        tick();
        chk("rsvd_wb_valid", wb_valid, 1);
        chk("rsvd_wb_data", wb_data, 32'h77);
        issue(2'd0, 32'h88, 32'h0, 1'b0, 4'd4);
        tick();
        in_valid = 1'b0;
        chk("nowb_valid", wb_valid, 0);
        chk("nowb_hold", wb_data, 32'h77);

        // stray ack outside MEM is ignored
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
        tick();
        dmem_ack = 1'b0;
        chk("stray_ack_wb", wb_valid, 0);
        chk("stray_ack_data", wb_data, 32'h77);

        // timeout: request held TIMEOUT+1 cycles then dropped
        issue(2'd1, 32'h200, 32'h0, 1'b1, 4'd8);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("to_req_held", dmem_req, 1);
            chk("to_not_yet", err_timeout, 0);
            tick();
        end
        chk("to_req_drop", dmem_req, 0);
        chk("to_err", err_timeout, 1);
        chk("to_no_wb", wb_valid, 0);
        chk("to_ready", in_ready, 1);
        tick();
        chk("to_sticky", err_timeout, 1);

        // ack on the very last counted cycle still succeeds
        issue(2'd1, 32'h300, 32'h0, 1'b1, 4'd4);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        chk("edge_req", dmem_req, 1);
        dmem_ack = 1'b1; dmem_rdata = 32'h1234;
        tick();
        dmem_ack = 1'b0;
        chk("edge_wb_valid", wb_valid, 1);
        chk("edge_wb_data", wb_data, 32'h1234);
        chk("edge_wb_addr", wb_addr, 4);
        tick();

        // reset clears the sticky timeout flag
        rst_n = 1'b0;
        tick();
        chk("rst_clr_to", err_timeout, 0);
        chk("rst_clr_wb", wb_data, 0);
        rst_n = 1'b1;
        tick();

        // reset in the middle of an access
        issue(2'd1, 32'h400, 32'h0, 1'b1, 4'd6);
        tick();
        in_valid = 1'b0;
        chk("mid_req", dmem_req, 1);
        rst_n = 1'b0;
        tick();
        chk("mid_req_drop", dmem_req, 0);
        chk("mid_addr_clr", dmem_addr, 0);
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE;
        tick();
        dmem_ack = 1'b0;
        chk("mid_no_wb", wb_valid, 0);
        chk("mid_ready", in_ready, 1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
